pcss_link_tx: RTL and testbench



---
 rtl/pcss_link_pkg.sv | 23 ++
 rtl/pcss_lane_sel.sv | 30 +++
 rtl/pcss_link_tx.sv | 171 +++++++++++++++++
 tb/tb_pcss_link_tx.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcss_link_pkg.sv
// Shared definitions for the host-to-chip link (tx and rx halves).
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pcss_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_RETRY = 2'd2
    } state_t;

    // Number of flit lanes carried by one stream word.
    function automatic int calc_nl(input int data_width, input int chipdata_width);
        return data_width / chipdata_width;
    endfunction

    // Flit parity. Callers zero-extend the flit; zero padding does not
    // change the XOR reduction. odd=0 gives even parity, odd=1 odd parity.
    function automatic logic calc_par(input logic [63:0] flit, input logic odd);
        return odd ? ~(^flit) : (^flit);
    endfunction

endpackage

// File: rtl/pcss_lane_sel.sv
// Priority selector: highest set lane in a mask, plus a flag when it is the only one left.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: mask (remaining kept lanes) -> idx (highest set), any (mask nonzero), last (idx is the sole set bit).
module pcss_lane_sel #(
    parameter int NL = 4,
    parameter int IW = (NL > 1) ? $clog2(NL) : 1
) (
    input  logic [NL-1:0] mask,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          last
);

    logic [NL-1:0] rest;

    always_comb begin
        idx = '0;
        // Ascending scan so the highest set lane wins.
        for (int i = 0; i < NL; i++) begin
            if (mask[i]) begin
                idx = IW'(i);
            end
        end
        any  = |mask;
        rest = mask & ~(NL'(1) << idx);
        last = any && (rest == '0);
    end

endmodule

// File: rtl/pcss_link_tx.sv
// Link transmitter: serialises 64-bit stream words into parity-protected flits, MSB lane first.
// Latency: word accepted in cycle T -> first flit valid in T+1; NL+1 cycles per full word.
// Backpressure: flit held while ready=0; err forces a one-cycle gap and resend, MAX_RETRY errs abandon the word.
// Ports: clk/rst (sync, active-high); s_axis_* stream in; send_data_* flit out with ready/err back;
//        frame_end pulse, sticky link_err, busy (not IDLE).
module pcss_link_tx
    import pcss_link_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int CHIPDATA_WIDTH = 16,
    parameter int PAR_ODD        = 0,
    parameter int MAX_RETRY      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    output logic                      s_axis_tready,
    output logic [CHIPDATA_WIDTH-1:0] send_data_out,
    output logic                      send_data_valid,
    output logic                      send_data_par,
    input  logic                      send_data_ready,
    input  logic                      send_data_err,
    output logic                      frame_end,
    output logic                      link_err,
    output logic                      busy
);

    localparam int NL = calc_nl(DATA_WIDTH, CHIPDATA_WIDTH);
    localparam int IW = (NL > 1) ? $clog2(NL) : 1;
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int KB = CHIPDATA_WIDTH / 8;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] word_r;
    logic [NL-1:0]         mask_r;     // lanes still to send, current lane included
    logic [NL-1:0]         mask_in;
    logic                  tlast_r;
    logic [RW-1:0]         retry_r;
    logic                  link_err_r;
    logic                  fe_empty_r; // frame_end for a word with no kept lanes

    logic [IW-1:0]         sel_idx;
    logic                  sel_any;
    logic                  sel_last;

    logic tready_c, valid_c, load, accept, reject, fault, fe_accept;
    logic [CHIPDATA_WIDTH-1:0] flit;
    logic [63:0]               par_ext;

    // A lane survives only if every one of its byte enables is set.
    always_comb begin
        mask_in = '0;
        for (int l = 0; l < NL; l++) begin
            mask_in[l] = &s_axis_tkeep[l*KB +: KB];
        end
    end

    pcss_lane_sel #(.NL(NL), .IW(IW)) u_lane_sel (
        .mask (mask_r),
        .idx  (sel_idx),
        .any  (sel_any),
        .last (sel_last)
    );

    // Flit is a slice of the held word selected by the held mask, so it is
    // stable across stalls and retries without a separate flit register.
    assign flit = word_r[int'(sel_idx)*CHIPDATA_WIDTH +: CHIPDATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tready_c  = 1'b0;
        valid_c   = 1'b0;
        load      = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        fault     = 1'b0;
        fe_accept = 1'b0;
        case (state)
            ST_IDLE: begin
                tready_c = !rst;
                if (s_axis_tvalid && tready_c) begin
                    load = 1'b1;
                    if (|mask_in) begin
                        state_nxt = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                valid_c = sel_any;
                // err wins over ready: a flagged flit is never counted as delivered.
                if (send_data_err) begin
                    reject = 1'b1;
                    if (retry_r == RW'(MAX_RETRY - 1)) begin
                        fault     = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_RETRY;
                    end
                end else if (send_data_ready) begin
                    accept = 1'b1;
                    if (sel_last) begin
                        state_nxt = ST_IDLE;
                        fe_accept = tlast_r;
                    end
                end
            end
            ST_RETRY: begin
                state_nxt = ST_SEND;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_r     <= '0;
            mask_r     <= '0;
            tlast_r    <= 1'b0;
            retry_r    <= '0;
            link_err_r <= 1'b0;
            fe_empty_r <= 1'b0;
        end else begin
            fe_empty_r <= load && !(|mask_in) && s_axis_tlast;
            if (load) begin
                word_r  <= s_axis_tdata;
                mask_r  <= mask_in;
                tlast_r <= s_axis_tlast;
                retry_r <= '0;
            end
            if (accept) begin
                mask_r  <= mask_r & ~(NL'(1) << sel_idx);
                retry_r <= '0;
            end
            if (reject) begin
                retry_r <= retry_r + 1'b1;
            end
            if (fault) begin
                link_err_r <= 1'b1;
                mask_r     <= '0;
                retry_r    <= '0;
            end
        end
    end

    always_comb begin
        par_ext = '0;
        par_ext[CHIPDATA_WIDTH-1:0] = send_data_out;
    end

    assign s_axis_tready   = tready_c;
    assign send_data_valid = valid_c;
    assign send_data_out   = (state != ST_IDLE) ? flit : '0;
    assign send_data_par   = (state != ST_IDLE) ? calc_par(par_ext, PAR_ODD != 0) : 1'b0;
    assign frame_end       = !rst && (fe_accept || fe_empty_r);
    assign link_err        = link_err_r;
    assign busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_pcss_link_tx.sv
// Directed bench for pcss_link_tx with a flit scoreboard.
// Latency: n/a (testbench).
// Backpressure: bench drives ready/err cycle by cycle.
module tb_pcss_link_tx;

    localparam int DW = 64;
    localparam int CW = 16;
    localparam int NL = DW / CW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic [DW/8-1:0] tkeep;
    logic          tready;
    logic [CW-1:0] dout;
    logic          dvalid;
    logic          dpar;
    logic          dready;
    logic          derr;
    logic          frame_end;
    logic          link_err;
    logic          busy;

    typedef struct {
        logic [CW-1:0] flit;
        logic          par;
        logic          fe;
        logic          bare;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pcss_link_tx #(
        .DATA_WIDTH(DW), .CHIPDATA_WIDTH(CW), .PAR_ODD(0), .MAX_RETRY(3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (tdata),
        .s_axis_tvalid   (tvalid),
        .s_axis_tlast    (tlast),
        .s_axis_tkeep    (tkeep),
        .s_axis_tready   (tready),
        .send_data_out   (dout),
        .send_data_valid (dvalid),
        .send_data_par   (dpar),
        .send_data_ready (dready),
        .send_data_err   (derr),
        .frame_end       (frame_end),
        .link_err        (link_err),
        .busy            (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: kept lanes MSB first, frame_end on the last kept one.
    task automatic push_word(input logic [DW-1:0] data, input logic [DW/8-1:0] keep, input logic last);
        int   last_l = -1;
        exp_t e;
        for (int l = 0; l < NL; l++) begin
            if (keep[2*l] && keep[2*l+1]) begin
                if (last_l < 0) last_l = l;
            end
        end
        for (int l = NL - 1; l >= 0; l--) begin
            if (keep[2*l] && keep[2*l+1]) begin
                e.flit = data[l*CW +: CW];
                e.par  = ^e.flit;
                e.fe   = last && (l == last_l);
                e.bare = 1'b0;
                exp_q.push_back(e);
            end
        end
        if (last && last_l < 0) begin
            e.flit = '0;
            e.par  = 1'b0;
            e.fe   = 1'b1;
            e.bare = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_flit(input logic [CW-1:0] f);
        exp_t e;
        e.flit = f;
        e.par  = ^f;
        e.fe   = 1'b0;
        e.bare = 1'b0;
        exp_q.push_back(e);
    endtask

    // Returns at the negedge of cycle T+1 (first flit cycle).
    task automatic send_word(input logic [DW-1:0] data, input logic [DW/8-1:0] keep,
                             input logic last, input bit do_push);
        int n = 0;
        if (do_push) push_word(data, keep, last);
        tdata  = data;
        tkeep  = keep;
        tlast  = last;
        tvalid = 1'b1;
        while (!tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_tready", tready, 1);
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    // Scoreboard monitor, sampling one time unit before the rising edge.
    always begin
        @(negedge clk);
        #4;
        if (!rst) begin
            if (dvalid && dready && !derr) begin
                chk("flit_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("sb_flit", dout, mon_e.flit);
                    chk("sb_par", dpar, mon_e.par);
                    chk("sb_frame_end", frame_end, mon_e.fe);
                end
            end else if (frame_end) begin
                chk("bare_fe_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("bare_fe", mon_e.bare, 1);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
        dready = 1'b1; derr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tready", tready, 0);
        chk("rst_valid", dvalid, 0);
        chk("rst_data", dout, 0);
        chk("rst_par", dpar, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_link_err", link_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_tready", tready, 1);
        @(negedge clk);

        // 1: full word, no backpressure
        send_word(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b1);
        chk("t1_valid", dvalid, 1);
        chk("t1_flit0", dout, 16'h0123);
        chk("t1_tready", tready, 0);
        chk("t1_busy", busy, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t1_valid_run", dvalid, 1);
        end
        chk("t1_frame_end", frame_end, 1);
        @(negedge clk);
        chk("t1_tready_after", tready, 1);
        chk("t1_valid_after", dvalid, 0);

        // 2: stall on flit 1
        send_word(64'h0001_0000_0000_0000, 8'hFF, 1'b0, 1'b1);
        chk("t2_flit0", dout, 16'h0001);
        chk("t2_par0", dpar, 1);
        @(negedge clk);
        dready = 1'b0;
        chk("t2_stall_data", dout, 16'h0000);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t2_stall_valid", dvalid, 1);
            chk("t2_stall_data", dout, 16'h0000);
        end
        @(negedge clk);
        chk("t2_stall_valid", dvalid, 1);
        chk("t2_stall_data", dout, 16'h0000);
        dready = 1'b1;
        wait_idle();

        // 3: single err then retry count restarts on the next flit
        send_word(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t3_flit2", dout, 16'h89AB);
        derr = 1'b1;
        @(negedge clk);
        chk("t3_retry_valid", dvalid, 0);
        chk("t3_retry_busy", busy, 1);
        derr = 1'b0;
        @(negedge clk);
        chk("t3_resend_valid", dvalid, 1);
        chk("t3_resend_flit", dout, 16'h89AB);
        @(negedge clk);
        chk("t3_flit3", dout, 16'hCDEF);
        derr = 1'b1;
        @(negedge clk);
        derr = 1'b0;
        @(negedge clk);
        chk("t3_flit3_again", dvalid, 1);
        derr = 1'b1;
        @(negedge clk);
        derr = 1'b0;
        chk("t3_no_fault", link_err, 0);
        chk("t3_retry2_valid", dvalid, 0);
        @(negedge clk);
        chk("t3_final_valid", dvalid, 1);
        chk("t3_final_flit", dout, 16'hCDEF);
        wait_idle();
        chk("t3_link_err", link_err, 0);

        // 4: retries exhausted on flit 1
        push_flit(16'hFEDC);
        send_word(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_flit1", dout, 16'hBA98);
        derr = 1'b1;
        @(negedge clk);
        derr = 1'b0;
        @(negedge clk);
        derr = 1'b1;
        @(negedge clk);
        derr = 1'b0;
        @(negedge clk);
        chk("t4_before_fault", link_err, 0);
        derr = 1'b1;
        @(negedge clk);
        derr = 1'b0;
        chk("t4_link_err", link_err, 1);
        chk("t4_valid", dvalid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_tready", tready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_no_more_flits", dvalid, 0);
            chk("t4_sticky", link_err, 1);
        end
        send_word(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b1);
        wait_idle();
        chk("t4_still_sticky", link_err, 1);

        // 5: lane masks
        send_word(64'h0123_4567_89AB_CDEF, 8'h0F, 1'b0, 1'b1);
        chk("t5_low_first", dout, 16'h89AB);
        wait_idle();
        send_word(64'h1111_2222_3333_4444, 8'h00, 1'b1, 1'b1);
        chk("t5_empty_valid", dvalid, 0);
        chk("t5_empty_fe", frame_end, 1);
        chk("t5_empty_busy", busy, 0);
        @(negedge clk);
        chk("t5_empty_fe_pulse", frame_end, 0);
        send_word(64'h1111_2222_3333_4444, 8'h00, 1'b0, 1'b1);
        chk("t5_empty_nolast_fe", frame_end, 0);
        send_word(64'h0123_4567_89AB_CDEF, 8'h3F, 1'b1, 1'b1);
        chk("t5_skip_lane3", dout, 16'h4567);
        wait_idle();
        send_word(64'hAAAA_BBBB_CCCC_DDDD, 8'hC3, 1'b1, 1'b1);
        chk("t5_c3_first", dout, 16'hAAAA);
        @(negedge clk);
        chk("t5_c3_second", dout, 16'hDDDD);
        wait_idle();

        // 6: reset mid-word
        push_flit(16'h0123);
        push_flit(16'h4567);
        send_word(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_flit2", dout, 16'h89AB);
        rst = 1'b1;
        dready = 1'b0;
        #1;
        chk("t6_rst_tready", tready, 0);
        chk("t6_rst_fe", frame_end, 0);
        @(negedge clk);
        chk("t6_valid", dvalid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_link_err", link_err, 0);
        chk("t6_data", dout, 0);
        chk("t6_tready_in_rst", tready, 0);
        rst = 1'b0;
        dready = 1'b1;
        #1;
        chk("t6_tready_after", tready, 1);
        send_word(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1, 1'b1);
        chk("t6_fresh_flit0", dout, 16'hFEDC);
        wait_idle();

        @(negedge clk);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
